// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU-side access bus and line-wide backing-memory bus of the data cache.
//   slave  : cache view (takes CPU requests and memory fills, drives load data, stall, memory requests)
//   master : environment view (CPU pipeline plus backing memory)
// Parameter WORDS sets the line width LW = 32*WORDS and must match the cache instance.
interface dcache_ctrl_if #(
  parameter int unsigned WORDS = 8
);
  localparam int unsigned LW = 32 * WORDS;

  logic [31:0]   addr_i;
  logic [31:0]   data_i;
  logic          memread_i;
  logic          memwrite_i;
  logic [31:0]   data_o;
  logic          stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic [LW-1:0] mem_rdata_i;
  logic          mem_ack_i;

  modport slave (
    input  addr_i, data_i, memread_i, memwrite_i, mem_rdata_i, mem_ack_i,
    output data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output addr_i, data_i, memread_i, memwrite_i, mem_rdata_i, mem_ack_i,
    input  data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-low reset (clears FSM, valid/dirty bits, request outputs)
//   bus         dcache_ctrl_if.slave: CPU addr/data/memread/memwrite, combinational data_o and
//               stall_o, registered line-wide backing-memory request (req/we/addr/wdata, rdata/ack)
//   hit_cnt_o   (DCACHE_STATS_EN only) saturating count of first-try hits
//   miss_cnt_o  (DCACHE_STATS_EN only) saturating count of misses
// Optional feature: define DCACHE_STATS_EN to add the hit/miss counters.
module dcache_ctrl #(
  parameter int unsigned LINES = 32,
  parameter int unsigned WORDS = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);
  localparam int unsigned LW    = 32 * WORDS;
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned LO_W  = OFF_W + 2;
  localparam int unsigned TAG_W = 32 - IDX_W - LO_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t           state_q, state_d;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LW-1:0]    data_q [LINES];

  logic             req_q, we_q;
  logic [31:0]      maddr_q;
  logic [LW-1:0]    wdata_q;

  logic [OFF_W-1:0] off_c;
  logic [IDX_W-1:0] idx_c;
  logic [TAG_W-1:0] tag_c;
  logic             access_c, hit_c, victim_dirty_c, req_ack_c, fill_c, wr_hit_c;
  logic [31:0]      wb_addr_c, fill_addr_c;
  logic             unused_addr_lsb;

  // Address split: byte lanes ignored, then word offset, line index, tag.
  assign off_c           = bus.addr_i[LO_W-1:2];
  assign idx_c           = bus.addr_i[LO_W+IDX_W-1:LO_W];
  assign tag_c           = bus.addr_i[31:LO_W+IDX_W];
  assign unused_addr_lsb = ^bus.addr_i[1:0];

  assign access_c       = bus.memread_i | bus.memwrite_i;
  assign hit_c          = access_c & valid_q[idx_c] & (tag_q[idx_c] == tag_c);
  assign victim_dirty_c = valid_q[idx_c] & dirty_q[idx_c];
  assign req_ack_c      = req_q & bus.mem_ack_i;
  assign fill_c         = (state_q == S_ALLOCATE) & req_ack_c;
  assign wb_addr_c      = {tag_q[idx_c], idx_c, {LO_W{1'b0}}};
  assign fill_addr_c    = {tag_c, idx_c, {LO_W{1'b0}}};

  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = maddr_q;
  assign bus.mem_wdata_o = wdata_q;

  // Next state, combinational stall and load data.
  always_comb begin
    state_d     = state_q;
    bus.stall_o = 1'b0;
    bus.data_o  = '0;
    wr_hit_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access_c) begin
          if (hit_c) begin
            if (bus.memwrite_i) wr_hit_c = 1'b1;
            else                bus.data_o = data_q[idx_c][{off_c, 5'd0} +: 32];
          end else begin
            bus.stall_o = 1'b1;
            state_d     = victim_dirty_c ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        bus.stall_o = 1'b1;
        if (req_ack_c) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        bus.stall_o = 1'b1;
        if (req_ack_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Valid bits are cleared while in reset, so a held access would otherwise look like a miss.
    if (!rst_i) bus.stall_o = 1'b0;
  end

  // FSM, line status and registered memory request.
  // The request drops for one cycle between write-back and fill so each ack pairs with a fresh request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_hit_c) dirty_q[idx_c] <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (state_d != S_IDLE) begin
            req_q   <= 1'b1;
            we_q    <= victim_dirty_c;
            maddr_q <= victim_dirty_c ? wb_addr_c : fill_addr_c;
            wdata_q <= data_q[idx_c];
          end
        end
        S_WRITEBACK: begin
          if (req_ack_c) begin
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            maddr_q        <= fill_addr_c;
            dirty_q[idx_c] <= 1'b0;
          end
        end
        S_ALLOCATE: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (bus.mem_ack_i) begin
            req_q          <= 1'b0;
            valid_q[idx_c] <= 1'b1;
            dirty_q[idx_c] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays keep their contents across reset.
  always_ff @(posedge clk_i) begin
    if (fill_c) begin
      data_q[idx_c] <= bus.mem_rdata_i;
      tag_q[idx_c]  <= tag_c;
    end else if (wr_hit_c) begin
      data_q[idx_c][{off_c, 5'd0} +: 32] <= bus.data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic refill_q;

  // Saturating counters; the hit seen right after a fill is the retried access, not a new hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      refill_q   <= 1'b0;
    end else begin
      refill_q <= fill_c;
      if ((state_q == S_IDLE) && hit_c && !refill_q && (hit_cnt_o != 32'hFFFF_FFFF))
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if ((state_q == S_IDLE) && (state_d != S_IDLE) && (miss_cnt_o != 32'hFFFF_FFFF))
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
module tb_dcache_ctrl;
  localparam int unsigned LINES = 32;
  localparam int unsigned WORDS = 8;
  localparam int unsigned LW    = 32 * WORDS;
  localparam int unsigned LBYTES = WORDS * 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  dcache_ctrl_if #(.WORDS(WORDS)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  dcache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          we;
    bit [31:0]   addr;
    bit [LW-1:0] line;
  } mem_txn_t;

  // Scoreboard queues: expected memory transactions, their ack latencies, expected load data.
  mem_txn_t    mem_q[$];
  int          lat_q[$];
  bit [31:0]   rd_q[$];
  bit          auto_mem = 1'b1;

  // Reference model: which line address occupies each slot, its contents and dirtiness.
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  bit [31:0]   m_base  [LINES];
  bit [LW-1:0] m_line  [LINES];
  bit [LW-1:0] bmem    [bit [31:0]];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit [LW-1:0] mem_line(input bit [31:0] base);
    bit [LW-1:0] l;
    if (bmem.exists(base)) return bmem[base];
    for (int w = 0; w < int'(WORDS); w++)
      l[w*32 +: 32] = (base + 32'(w * 4)) ^ 32'hC3A5_5A3C;
    return l;
  endfunction

  // Apply one CPU access: update the model, queue expectations, drive, and count stall cycles.
  task automatic do_access(input bit [31:0] a, input bit [31:0] d, input bit rd, input bit wr,
                           input int l1, input int l2);
    int        slot, word, exp_stall, got;
    bit [31:0] base;
    base      = a & ~32'(LBYTES - 1);
    slot      = int'((a / LBYTES) % LINES);
    word      = int'((a % LBYTES) / 4);
    exp_stall = 0;
    if (rd || wr) begin
      if (m_valid[slot] && m_base[slot] == base) begin
        exp_hits++;
      end else begin
        exp_misses++;
        if (m_valid[slot] && m_dirty[slot]) begin
          mem_q.push_back('{1'b1, m_base[slot], m_line[slot]});
          lat_q.push_back(l1);
          bmem[m_base[slot]] = m_line[slot];
          exp_stall += 1 + l1;
        end
        m_line[slot]  = mem_line(base);
        m_base[slot]  = base;
        m_valid[slot] = 1'b1;
        m_dirty[slot] = 1'b0;
        mem_q.push_back('{1'b0, base, m_line[slot]});
        lat_q.push_back(l2);
        exp_stall += 1 + l2;
      end
      if (wr) begin
        m_line[slot][word*32 +: 32] = d;
        m_dirty[slot] = 1'b1;
      end else begin
        rd_q.push_back(m_line[slot][word*32 +: 32]);
      end
    end
    @(posedge clk_i); #1;
    bus.addr_i     = a;
    bus.data_i     = d;
    bus.memread_i  = rd;
    bus.memwrite_i = wr;
    got = 0;
    forever begin
      @(negedge clk_i);
      if (!bus.stall_o || got > 200) break;
      got++;
    end
    check32("stall_cycles", 32'(got), 32'(exp_stall));
  endtask

  // Backing-memory responder: checks each request against the queue and acks after its latency.
  initial begin
    mem_txn_t t;
    int       l;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (auto_mem && rst_i && bus.mem_req_o) begin
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_req actual=1 expected=0 addr=%h t=%0t", bus.mem_addr_o, $time);
        end else begin
          t = mem_q.pop_front();
          l = lat_q.pop_front();
          check32("mem_we", 32'(bus.mem_we_o), 32'(t.we));
          check32("mem_addr", bus.mem_addr_o, t.addr);
          if (t.we) check_line("mem_wdata", bus.mem_wdata_o, t.line);
          repeat (l - 1) @(negedge clk_i);
          check32("mem_req_held", 32'(bus.mem_req_o), 32'd1);
          check32("mem_addr_held", bus.mem_addr_o, t.addr);
          bus.mem_rdata_i = t.we ? '0 : t.line;
          bus.mem_ack_i   = 1'b1;
          @(posedge clk_i); #1;
          bus.mem_ack_i   = 1'b0;
        end
      end
    end
  end

  // Output monitor: an unstalled load presents data_o; anything else must show zero.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i && !bus.stall_o) begin
        if (bus.memread_i && !bus.memwrite_i) begin
          if (rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL load_unexpected actual=%h expected=none t=%0t", bus.data_o, $time);
          end else begin
            check32("load_data", bus.data_o, rd_q.pop_front());
          end
        end else begin
          check32("data_o_zero", bus.data_o, 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [LW-1:0] l0;
    bit [31:0]   a;
    int          got;
    bus.addr_i     = '0;
    bus.data_i     = '0;
    bus.memread_i  = 1'b0;
    bus.memwrite_i = 1'b0;
    l0 = mem_line(32'h40);
    l0[31:0] = 32'hDEAD_BEEF;
    bmem[32'h40] = l0;

    #2 rst_i = 1'b0;
    #1;
    check32("rst_stall", 32'(bus.stall_o), 32'd0);
    check32("rst_req", 32'(bus.mem_req_o), 32'd0);
    check32("rst_we", 32'(bus.mem_we_o), 32'd0);
    check32("rst_addr", bus.mem_addr_o, 32'd0);
    check32("rst_data", bus.data_o, 32'd0);
`ifdef DCACHE_STATS_EN
    check32("rst_hit_cnt", hit_cnt_o, 32'd0);
    check32("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Directed scenarios.
    do_access(32'h40, 32'h0, 1'b1, 1'b0, 1, 3);
    do_access(32'h44, 32'h1234_5678, 1'b0, 1'b1, 1, 1);
    do_access(32'h44, 32'h0, 1'b1, 1'b0, 1, 1);
    do_access(32'h440, 32'h0, 1'b1, 1'b0, 2, 2);
    do_access(32'h40, 32'h0, 1'b1, 1'b0, 1, 2);

    // Randomised traffic over a few slots and tags to force conflicts and write-backs.
    for (int n = 0; n < 300; n++) begin
      int op;
      a  = (32'($urandom_range(3, 0)) << 10) | (32'($urandom_range(3, 0)) << 5)
         | (32'($urandom_range(WORDS - 1, 0)) << 2) | 32'($urandom_range(3, 0));
      op = int'($urandom_range(3, 0));
      do_access(a, $urandom, (op == 0) || (op == 2), (op == 1) || (op == 2),
                int'($urandom_range(4, 1)), int'($urandom_range(4, 1)));
    end

    // Reset in the middle of a fill.
    a = 32'h0001_0284;
    auto_mem = 1'b0;
    @(posedge clk_i); #1;
    bus.addr_i     = a;
    bus.memread_i  = 1'b1;
    bus.memwrite_i = 1'b0;
    got = 0;
    while (!bus.mem_req_o && got < 20) begin
      @(negedge clk_i);
      got++;
    end
    check32("alloc_req", 32'(bus.mem_req_o), 32'd1);
    check32("alloc_we", 32'(bus.mem_we_o), 32'd0);
    check32("alloc_addr", bus.mem_addr_o, 32'h0001_0280);
    rst_i = 1'b0;
    #1;
    check32("midrst_stall", 32'(bus.stall_o), 32'd0);
    check32("midrst_req", 32'(bus.mem_req_o), 32'd0);
    check32("midrst_we", 32'(bus.mem_we_o), 32'd0);
    check32("midrst_addr", bus.mem_addr_o, 32'd0);
    check32("midrst_data", bus.data_o, 32'd0);
    bus.memread_i = 1'b0;
    for (int s = 0; s < int'(LINES); s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    bus.mem_rdata_i = {WORDS{32'hBAD0_BAD0}};
    bus.mem_ack_i   = 1'b1;
    @(posedge clk_i); #1;
    bus.mem_ack_i   = 1'b0;
    @(negedge clk_i);
    check32("stray_ack_req", 32'(bus.mem_req_o), 32'd0);
    check32("stray_ack_stall", 32'(bus.stall_o), 32'd0);
    auto_mem = 1'b1;

    // After reset: miss, hit, hit, miss.
    do_access(a, 32'h0, 1'b1, 1'b0, 1, 2);
    do_access(a, 32'h0, 1'b1, 1'b0, 1, 1);
    do_access(a + 32'h4, 32'h0, 1'b1, 1'b0, 1, 1);
    do_access(a + 32'h400, 32'h0, 1'b1, 1'b0, 1, 3);
`ifdef DCACHE_STATS_EN
    check32("hit_cnt", hit_cnt_o, 32'(exp_hits));
    check32("miss_cnt", miss_cnt_o, 32'(exp_misses));
`endif

    @(posedge clk_i); #1;
    bus.memread_i  = 1'b0;
    bus.memwrite_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check32("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check32("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
